single_port_ram: RTL and testbench
==================================

# single_port_ram

Synchronous single-port RAM: one address bus shared by reads and writes, a write-enable, a registered read address and a read-data output. Used as a small general-purpose scratch memory inside datapath blocks. The memory is register-based, so synchronous reset can clear it to a known state.

## Interface
- `data_width`, default 8: width of each memory word, `data` and `q`.
- `addr_width`, default 8: width of `addr`.
- `depth`, default 64: number of words. Must satisfy depth ≤ 2^addr_width. Valid addresses are 0..depth-1.

- `clk`  input  1: single clock; all state updates on the rising edge.
- `rst_n`  input  1: reset, synchronous and active-low. Sampled on the rising edge of `clk`.
- `data`  input  data_width: write data.
- `addr`  input  addr_width: shared read/write address.
- `we`  input  1: write enable, active-high.
- `q`  output  data_width: read data for the registered address.

## Operation
- Storage is an array of `depth` words of `data_width` bits, plus an internal registered address `addr_reg` (addr_width bits).
- Reset: on a rising edge with rst_n=0:
  - every memory word is cleared to 0;
  - `addr_reg` is cleared to 0;
  - `we` is ignored.
- Normal edge (rst_n=1):
  - if we=1 and addr < depth, mem[addr] takes `data`;
  - `addr_reg` takes `addr` every cycle, whatever the value of `we`.
- Read path: q = mem[addr_reg], combinational from the registered address and current memory contents.
- Out of range (address ≥ depth):
  - writes are silently dropped and memory is unchanged;
  - when addr_reg ≥ depth, q = 0.
- Write-first behaviour: after a write edge, q shows the newly written word at that address.
- No other ports, flags or error outputs.

## Timing
- Read latency is 1 cycle. `addr` is presented before edge N, and `q` is valid after edge N. It stays stable until the next edge that changes `addr_reg` or writes mem[addr_reg].
- Write latency: data is stored at the edge where we=1. A read of the same address issued at that same edge returns the new data after that edge, never the old data.
- Back-to-back operations: a write to A at edge N followed by a read of A at edge N+1 returns the written value. There are no bubbles, and a new address is accepted every cycle.
- Consecutive writes to the same address: the last one wins.
- After reset, q = 0, because addr_reg=0 and mem[0]=0. q is 0 in the cycle following the reset edge.
- Reset mid-operation: reset takes priority over `we`. Contents written before the reset are lost.
- Before the first reset edge, memory and q are undefined. The bench must apply reset first.
- `data` and `we` are don't-care when not writing.

## Test plan
- Reset: hold rst_n=0 for 2 edges, then release with we=0 and addr=0..63 swept -> q=0 for every address.
- Write then read:
  - writes: we=1, data 8'h01 at addr 0, 8'h02 at addr 1, 8'h03 at addr 2, one per cycle;
  - reads: then we=0 with addr 0, 1, 2;
  - required: q = 01, 02, 03 one cycle after each read address.
  - Repeat this 5 times and require identical results.
- Write-first: we=1, addr=5, data=8'hA5 -> q=A5 after that same edge. Next, we=1, addr=5, data=8'h5A -> q=5A.
- Read hold with no write enable: fill addr 10 with 8'h3C, then present addr=10 with we=0 and data toggling randomly for 4 cycles -> q stays 3C and mem[10] is unchanged.
- Out of range: we=1, addr=64, data=8'hFF -> q=0 and no word changes. Read addr 0 (previously 01) -> q=01. Read addr=200 -> q=0.
- Reset mid-run: write 8'h77 to addr 3, assert rst_n=0 for one edge with we=1, addr=4, data=8'h99 -> q=0. Then read addrs 3 and 4 -> both 0.

Source files
------------

// File: rtl/single_port_ram.sv
// -----------------------------------------------------------------------------
// single_port_ram
//
// Purpose:
//   Small synchronous single-port scratch memory for datapath blocks. Reads and
//   writes share one address bus. The read address is registered, and the read
//   data is a combinational lookup of the current contents. Because of this, a
//   write at an edge is visible on q straight after that same edge
//   (write-first behaviour). Storage is built from flops, so a synchronous reset
//   can clear every word.
//
// Parameters:
//   data_width : bits per word (data, q)
//   addr_width : bits of addr
//   depth      : number of words, depth <= 2**addr_width
//
// Ports:
//   clk   in  1           rising-edge clock for all state
//   rst_n in  1           synchronous active-low reset; clears memory and
//                         the registered address, and overrides we
//   data  in  data_width  write data
//   addr  in  addr_width  shared read/write address
//   we    in  1           write enable, active-high
//   q     out data_width  word at the registered address (0 when out of range)
// -----------------------------------------------------------------------------
module single_port_ram #(
   parameter int data_width = 8,
   parameter int addr_width = 8,
   parameter int depth      = 64
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [data_width-1:0] data,
   input  logic [addr_width-1:0] addr,
   input  logic                  we,
   output logic [data_width-1:0] q
);

   // Width of the index into the storage array.
   localparam int lp_idx_w = (depth > 1) ? $clog2(depth) : 1;
   // depth can equal 2**addr_width, so it gets one extra bit for the compare.
   localparam logic [addr_width:0] lp_depth = (addr_width + 1)'(depth);

   logic [data_width-1:0] r_mem [depth];
   logic [addr_width-1:0] r_addr_reg;

   logic                  w_wr_ok;
   logic                  w_rd_ok;
   logic [lp_idx_w-1:0]   w_wr_idx;
   logic [lp_idx_w-1:0]   w_rd_idx;

   // Range checks run on the full address. The truncated index is used only
   // when the range check passes, so an out-of-range address never aliases
   // onto a valid word.
   assign w_wr_ok  = ({1'b0, addr} < lp_depth);
   assign w_rd_ok  = ({1'b0, r_addr_reg} < lp_depth);
   assign w_wr_idx = addr[lp_idx_w-1:0];
   assign w_rd_idx = r_addr_reg[lp_idx_w-1:0];

   // NOTE: non-blocking assignments on all sequential state. Every flop then
   // samples its pre-edge value, independent of the order of the statements.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         // NOTE: the memory is reset on purpose. It is flop-based, and users
         // rely on reading zeros after reset. A RAM macro could not do this.
         for (int i = 0; i < depth; i++) begin
            r_mem[i] <= '0;
         end
         r_addr_reg <= '0;
      end else begin
         if (we && w_wr_ok) begin
            r_mem[w_wr_idx] <= data;
         end
         r_addr_reg <= addr;
      end
   end

   // NOTE: q gets a default value before the conditional, so that no latch is
   // inferred for the out-of-range case.
   always_comb begin
      q = '0;
      if (w_rd_ok) begin
         q = r_mem[w_rd_idx];
      end
   end

endmodule

// File: tb/tb_single_port_ram.sv
// -----------------------------------------------------------------------------
// tb_single_port_ram
//
// Purpose:
//   Directed self-checking bench for single_port_ram with default parameters
//   (8-bit data, 8-bit address, 64 words). Inputs change 1 ns after each rising
//   edge, and q is checked at the same point. This gives each check the
//   contents and registered address produced by that edge.
// -----------------------------------------------------------------------------
module tb_single_port_ram;

   logic       clk;
   logic       rst_n;
   logic [7:0] data;
   logic [7:0] addr;
   logic       we;
   logic [7:0] q;

   int n_checks;
   int n_fails;

   single_port_ram #(
      .data_width (8),
      .addr_width (8),
      .depth      (64)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .data  (data),
      .addr  (addr),
      .we    (we),
      .q     (q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_write(input logic [7:0] a, input logic [7:0] d);
      we   = 1'b1;
      addr = a;
      data = d;
      tick();
   endtask

   task automatic do_read(input logic [7:0] a);
      we   = 1'b0;
      addr = a;
      data = 8'($urandom_range(255, 0));
      tick();
   endtask

   initial begin
      n_checks = 0;
      n_fails  = 0;
      rst_n    = 1'b0;
      we       = 1'b0;
      addr     = 8'h00;
      data     = 8'h00;

      // Reset for two edges, then sweep every valid address: all words read 0.
      tick();
      tick();
      check("reset_q", q, 8'h00);
      rst_n = 1'b1;
      for (int a = 0; a < 64; a++) begin
         do_read(8'(a));
         check($sformatf("reset_sweep_%0d", a), q, 8'h00);
      end

      // Write 01/02/03 to addresses 0..2, read them back. Repeated five times.
      for (int rep = 0; rep < 5; rep++) begin
         for (int a = 0; a < 3; a++) begin
            do_write(8'(a), 8'(a + 1));
            check($sformatf("wr_q_rep%0d_a%0d", rep, a), q, 8'(a + 1));
         end
         for (int a = 0; a < 3; a++) begin
            do_read(8'(a));
            check($sformatf("rd_rep%0d_a%0d", rep, a), q, 8'(a + 1));
         end
      end

      // Write-first: the new word is visible right after the write edge.
      do_write(8'd5, 8'hA5);
      check("wf_first", q, 8'hA5);
      do_write(8'd5, 8'h5A);
      check("wf_second", q, 8'h5A);
      do_read(8'd5);
      check("wf_last_wins", q, 8'h5A);

      // Read hold: with we=0, random data must not disturb the word.
      do_write(8'd10, 8'h3C);
      for (int i = 0; i < 4; i++) begin
         do_read(8'd10);
         check($sformatf("hold_%0d", i), q, 8'h3C);
      end
      do_read(8'd9);
      check("hold_neighbour", q, 8'h00);
      do_read(8'd10);
      check("hold_reread", q, 8'h3C);

      // Top valid address.
      do_write(8'd63, 8'hC3);
      check("top_write", q, 8'hC3);

      // Out-of-range write is dropped. 64 must not alias onto address 0.
      do_write(8'd64, 8'hFF);
      check("oor_write_q", q, 8'h00);
      do_read(8'd0);
      check("oor_addr0", q, 8'h01);
      do_read(8'd63);
      check("oor_addr63", q, 8'hC3);
      do_read(8'd200);
      check("oor_read_200", q, 8'h00);
      do_read(8'd255);
      check("oor_read_255", q, 8'h00);
      do_read(8'd64);
      check("oor_read_64", q, 8'h00);

      // Reset mid-run takes priority over a pending write.
      do_write(8'd3, 8'h77);
      check("mid_pre_write", q, 8'h77);
      rst_n = 1'b0;
      we    = 1'b1;
      addr  = 8'd4;
      data  = 8'h99;
      tick();
      check("mid_reset_q", q, 8'h00);
      rst_n = 1'b1;
      do_read(8'd3);
      check("mid_addr3", q, 8'h00);
      do_read(8'd4);
      check("mid_addr4", q, 8'h00);
      do_read(8'd0);
      check("mid_addr0", q, 8'h00);
      do_read(8'd63);
      check("mid_addr63", q, 8'h00);

      // Back-to-back write then read after the reset.
      do_write(8'd4, 8'h4E);
      do_read(8'd4);
      check("b2b_read", q, 8'h4E);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
      $finish;
   end

endmodule
